hydra_ingress_framer: RTL and testbench

- Per-port ingress stage that sits directly upstream of one hydra write port (wr_sop/wr_vld/wr_data/wr_eop, pause).
- Accepts a host word stream with valid/last and stores one packet at a time (store-and-forward).
- Once the packet is complete, emits it in the hydra write protocol: SOP cycle, header word {len[8:0], prio[2:0], dest[3:0]}, payload words, then EOP cycle.

---
 rtl/hydra_pkg.sv | 16 +
 rtl/hydra_framer_buf.sv | 21 ++
 rtl/hydra_ingress_framer.sv | 133 +++++++++++++
 tb/tb_hydra_ingress_framer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared types and constants for the hydra ingress framer and write-port logic.
package hydra_pkg;

    localparam int PORT_W = 4;
    localparam int PRIO_W = 3;
    localparam int LEN_W  = 9;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [PRIO_W-1:0] prio;
        logic [PORT_W-1:0] dest;
    } hdr_t;

    typedef enum logic [2:0] {FILL, DISCARD, WAIT, SOP, HDR, DATA, EOP} framer_state_t;

endpackage

// File: rtl/hydra_framer_buf.sv
// Simple dual-port packet buffer, one write port and one registered read port.
module hydra_framer_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hydra_ingress_framer.sv
// Store-and-forward ingress framer feeding one hydra write port.
// Optional packet/truncation counters under HYDRA_FRAMER_STATS_EN.
module hydra_ingress_framer
    import hydra_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    input  logic        in_last,
    input  logic [15:0] in_data,
    input  logic [2:0]  in_prio,
    input  logic [3:0]  in_dest,
    output logic        in_ready,
    output logic        wr_sop,
    output logic        wr_vld,
    output logic [15:0] wr_data,
    output logic        wr_eop,
    input  logic        pause,
    output logic        trunc_err
`ifdef HYDRA_FRAMER_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] trunc_cnt
`endif
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    framer_state_t     state, state_nx;
    logic [LEN_W-1:0]  cnt, idx, len;
    logic [PRIO_W-1:0] prio;
    logic [PORT_W-1:0] dest;
    logic              accept, trunc_hit, data_sel;
    logic [15:0]       hdr_q, rdata;
    hdr_t              hdr;

    assign hdr = '{len: len, prio: prio, dest: dest};

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        trunc_hit = 1'b0;
        case (state)
            FILL: begin
                accept = in_vld && in_ready;
                if (accept) begin
                    if (in_last) begin
                        state_nx = WAIT;
                    end else if (cnt + 1'b1 == DEPTH_L) begin
                        state_nx  = DISCARD;
                        trunc_hit = 1'b1;
                    end
                end
            end
            DISCARD: if (in_vld && in_last) state_nx = WAIT;
            WAIT:    if (!pause) state_nx = SOP;
            SOP:     state_nx = HDR;
            HDR:     state_nx = DATA;
            // idx runs one ahead of the word on wr_data because of the read latency
            DATA:    if (idx == len) state_nx = EOP;
            EOP:     state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            idx       <= '0;
            len       <= '0;
            prio      <= '0;
            dest      <= '0;
            in_ready  <= 1'b1;
            wr_sop    <= 1'b0;
            wr_vld    <= 1'b0;
            wr_eop    <= 1'b0;
            trunc_err <= 1'b0;
            data_sel  <= 1'b0;
            hdr_q     <= '0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == FILL) || (state_nx == DISCARD);
            wr_sop    <= (state_nx == SOP);
            wr_vld    <= (state_nx == HDR) || (state_nx == DATA);
            wr_eop    <= (state_nx == EOP);
            data_sel  <= (state_nx == DATA);
            trunc_err <= trunc_hit;
            hdr_q     <= (state_nx == HDR) ? hdr : '0;
            idx       <= (state_nx == DATA) ? idx + 1'b1 : '0;
            if (accept) begin
                cnt <= cnt + 1'b1;
                if (cnt == '0) begin
                    prio <= in_prio;
                    dest <= in_dest;
                end
                if (in_last)        len <= cnt + 1'b1;
                else if (trunc_hit) len <= DEPTH_L;
            end
            if (state == EOP) cnt <= '0;
        end
    end

    assign wr_data = data_sel ? rdata : hdr_q;

    hydra_framer_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (cnt[AW-1:0]),
        .wdata (in_data),
        .raddr (idx[AW-1:0]),
        .rdata (rdata)
    );

`ifdef HYDRA_FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt   <= '0;
            trunc_cnt <= '0;
        end else begin
            if (state == EOP) pkt_cnt <= pkt_cnt + 1'b1;
            if (trunc_hit)    trunc_cnt <= trunc_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hydra_ingress_framer.sv
// Self-checking bench for hydra_ingress_framer against a packet-level reference model.
module tb_hydra_ingress_framer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = '0;
    logic [2:0]  in_prio = '0;
    logic [3:0]  in_dest = '0;
    logic        pause = 1'b0;
    logic        in_ready, wr_sop, wr_vld, wr_eop, trunc_err;
    logic [15:0] wr_data;
`ifdef HYDRA_FRAMER_STATS_EN
    logic [15:0] pkt_cnt, trunc_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int trunc_seen = 0;
    int exp_pkt = 0;
    int exp_trunc = 0;

    hydra_ingress_framer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_prio   (in_prio),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .wr_sop    (wr_sop),
        .wr_vld    (wr_vld),
        .wr_data   (wr_data),
        .wr_eop    (wr_eop),
        .pause     (pause),
        .trunc_err (trunc_err)
`ifdef HYDRA_FRAMER_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .trunc_cnt (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && trunc_err) trunc_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sop"}, wr_sop, 1'b0);
        chk({tag, "_vld"}, wr_vld, 1'b0);
        chk({tag, "_eop"}, wr_eop, 1'b0);
        chk({tag, "_data"}, wr_data, 16'h0000);
        chk({tag, "_trunc"}, trunc_err, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b1);
    endtask

    task automatic chk_stats;
`ifdef HYDRA_FRAMER_STATS_EN
        chk("pkt_cnt", pkt_cnt, 32'(exp_pkt & 16'hFFFF));
        chk("trunc_cnt", trunc_cnt, 32'(exp_trunc & 16'hFFFF));
`endif
    endtask

    // n host beats; first_word < 0 means random payload. rst_mid resets during the payload.
    task automatic send_frame(input int n, input int pr, input int ds, input int first_word,
                              input int pause_cyc, input bit pause_mid, input bit rst_mid);
        logic [15:0] words[$];
        logic [15:0] w;
        logic [15:0] h;
        int len;
        int tr_before;
        len = (n > DEPTH) ? DEPTH : n;
        tr_before = trunc_seen;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) begin
                in_vld = 1'b0;
                tick();
            end
            w = (i == 0 && first_word >= 0) ? 16'(first_word) : 16'($urandom);
            words.push_back(w);
            in_vld  = 1'b1;
            in_data = w;
            in_last = (i == n - 1);
            in_prio = (i == 0) ? 3'(pr) : 3'($urandom);
            in_dest = (i == 0) ? 4'(ds) : 4'($urandom);
            chk("in_ready_accept", in_ready, 1'b1);
            tick();
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
        if (pause_cyc > 0) pause = 1'b1;
        for (int p = 0; p < pause_cyc; p++) begin
            tick();
            chk("sop_during_pause", wr_sop, 1'b0);
            chk("ready_during_pause", in_ready, 1'b0);
        end
        pause = 1'b0;
        tick();
        chk("sop", wr_sop, 1'b1);
        chk("sop_vld", wr_vld, 1'b0);
        chk("sop_ready", in_ready, 1'b0);
        tick();
        h = 16'((len << 7) | (pr << 4) | ds);
        chk("hdr_vld", wr_vld, 1'b1);
        chk("hdr_sop", wr_sop, 1'b0);
        chk("hdr_data", wr_data, h);
        for (int i = 0; i < len; i++) begin
            if (pause_mid && i == len / 2) pause = 1'b1;
            tick();
            chk("data_vld", wr_vld, 1'b1);
            chk("data_word", wr_data, words[i]);
            chk("data_ready", in_ready, 1'b0);
            if (rst_mid && i == 1) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk_idle_outputs("rst_mid");
                exp_pkt = 0;
                exp_trunc = 0;
                chk_stats();
                return;
            end
        end
        pause = 1'b0;
        tick();
        chk("eop", wr_eop, 1'b1);
        chk("eop_vld", wr_vld, 1'b0);
        chk("eop_ready", in_ready, 1'b0);
        tick();
        chk("post_eop", wr_eop, 1'b0);
        chk("post_ready", in_ready, 1'b1);
        chk("trunc_pulses", 32'(trunc_seen - tr_before), (n > DEPTH) ? 32'd1 : 32'd0);
        exp_pkt++;
        if (n > DEPTH) exp_trunc++;
        chk_stats();
    endtask

    initial begin
        tick();
        tick();
        chk_idle_outputs("reset");
        chk_stats();
        rst_n = 1'b1;
        tick();

        send_frame(31, 4, 3, -1, 0, 1'b0, 1'b0);
        send_frame(1, 0, 0, 16'hABCD, 0, 1'b0, 1'b0);
        send_frame(8, 2, 9, -1, 5, 1'b1, 1'b0);
        send_frame(70, 5, 12, -1, 0, 1'b0, 1'b0);
        send_frame(64, 1, 1, -1, 0, 1'b0, 1'b0);
        send_frame(10, 7, 15, -1, 0, 1'b0, 1'b1);
        send_frame(2, 3, 6, -1, 0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            send_frame($urandom_range(80, 1), $urandom_range(7), $urandom_range(15), -1,
                       $urandom_range(3), 1'($urandom_range(1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
